fetch_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_sequencer_if.sv | 40 ++++
 rtl/instr_byte_assembler.sv | 45 ++++
 rtl/fetch_sequencer.sv | 99 +++++++++
 tb/tb_fetch_sequencer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch definitions: fetch FSM states, byte-index type and PC constants.
package cpu_pkg;

  localparam int BYTES_PER_INSTR  = 4;
  localparam int ROM_READ_LATENCY = 1;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HOLD
  } fetch_state_e;

  typedef logic [$clog2(BYTES_PER_INSTR)-1:0] byte_idx_t;

  // Clears the two low bits of a PC so that it is word-aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM, redirect and decode-side signals of the fetch sequencer, grouped as one bus.
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 12
);

  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [7:0]            rom_data;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr;
  logic [31:0]           instr_pc;
  logic                  misalign_err;

  modport master (
    output rom_addr,
    input  rom_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    output misalign_err
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    input  misalign_err
  );

endinterface

// File: rtl/instr_byte_assembler.sv
// Tracks which byte each issued ROM read belongs to and writes the returning
// byte into a 32-bit little-endian instruction register one cycle later.
module instr_byte_assembler
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue,
  input  byte_idx_t   issue_idx,
  input  logic        flush,
  input  logic [7:0]  rom_data,
  output logic [31:0] instr
);

  logic        cap_valid_q, cap_valid_d;
  byte_idx_t   cap_idx_q, cap_idx_d;
  logic [31:0] instr_q, instr_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cap_valid_d = issue & ~flush;
    cap_idx_d   = issue_idx;
    instr_d     = instr_q;
    // A flush drops both the byte landing now and the read still in flight.
    if (cap_valid_q && !flush) begin
      instr_d[{cap_idx_q, 3'b000} +: 8] = rom_data;
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      instr_q     <= '0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      instr_q     <= instr_d;
    end
  end

  assign instr = instr_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch: four byte reads per instruction from a synchronous ROM,
// little-endian assembly, valid/ready hand-off to decode and PC redirects.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  byte_idx_t    byte_cnt_q, byte_cnt_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         misalign_q, misalign_d;
  logic         issue;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    byte_cnt_d    = byte_cnt_q;
    instr_valid_d = instr_valid_q;
    instr_pc_d    = instr_pc_q;
    issue         = 1'b0;

    unique case (state_q)
      FETCH: begin
        issue      = 1'b1;
        byte_cnt_d = byte_cnt_q + 1'b1;
        if (byte_cnt_q == byte_idx_t'(BYTES_PER_INSTR - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d       = HOLD;
        instr_valid_d = 1'b1;
        instr_pc_d    = pc_q;
      end
      HOLD: begin
        if (instr_valid_q && bus.instr_ready) begin
          state_d       = FETCH;
          pc_d          = pc_q + 32'd4;
          byte_cnt_d    = '0;
          instr_valid_d = 1'b0;
        end
      end
      default: state_d = FETCH;
    endcase

    // Redirect overrides everything, including a handshake on the same edge.
    if (bus.redirect_valid) begin
      state_d       = FETCH;
      pc_d          = align_pc(bus.redirect_pc);
      byte_cnt_d    = '0;
      instr_valid_d = 1'b0;
    end

    misalign_d = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      byte_cnt_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      byte_cnt_q    <= byte_cnt_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
      misalign_q    <= misalign_d;
    end
  end

  instr_byte_assembler u_assembler (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (issue),
    .issue_idx (byte_cnt_q),
    .flush     (bus.redirect_valid),
    .rom_data  (bus.rom_data),
    .instr     (bus.instr)
  );

  // byte_cnt is zero outside FETCH, so DRAIN and HOLD present pc itself.
  assign bus.rom_addr     = pc_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(byte_cnt_q);
  assign bus.instr_valid  = instr_valid_q;
  assign bus.instr_pc     = instr_pc_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a synchronous byte ROM model.
module tb_fetch_sequencer;

  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   xfer_cnt = 0;
  int   pc0_valid_cnt = 0;
  logic watch_pc0 = 1'b0;
  int   snap;
  logic [7:0] rom_mem [0:(1<<AW)-1];

  fetch_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  fetch_sequencer #(.ADDR_WIDTH(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  always @(posedge clk) begin
    if (rst_n && bus.instr_valid && bus.instr_ready) xfer_cnt = xfer_cnt + 1;
    if (watch_pc0 && bus.instr_valid && bus.instr_pc == 32'h0) pc0_valid_cnt = pc0_valid_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_hold(input string tag, input logic [31:0] ins, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "_instr"}, bus.instr, ins);
    check({tag, "_pc"}, bus.instr_pc, pc);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 8'(i ^ 8'hA5);
    rom_mem[12'h000] = 8'h13; rom_mem[12'h001] = 8'h05; rom_mem[12'h002] = 8'h10; rom_mem[12'h003] = 8'h00;
    rom_mem[12'h004] = 8'h93; rom_mem[12'h005] = 8'h05; rom_mem[12'h006] = 8'h20; rom_mem[12'h007] = 8'h00;
    rom_mem[12'h040] = 8'hB7; rom_mem[12'h041] = 8'h12; rom_mem[12'h042] = 8'h34; rom_mem[12'h043] = 8'h56;
    rom_mem[12'h044] = 8'h33; rom_mem[12'h045] = 8'h02; rom_mem[12'h046] = 8'h31; rom_mem[12'h047] = 8'h00;
    rom_mem[12'hFFC] = 8'h6F; rom_mem[12'hFFD] = 8'h00; rom_mem[12'hFFE] = 8'h00; rom_mem[12'hFFF] = 8'h00;

    // Basic fetch, latency and throughput.
    bus.instr_ready = 1'b1;
    do_reset();
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_pc", bus.instr_pc, 32'h0);
    check("rst_misalign", 32'(bus.misalign_err), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("addr_c%0d", c), 32'(bus.rom_addr), 32'(c));
      step();
    end
    check("c4_not_valid", 32'(bus.instr_valid), 32'd0);
    step();
    check_hold("first", 32'h0010_0513, 32'h0);
    snap = xfer_cnt;
    step();
    check("c6_addr", 32'(bus.rom_addr), 32'h4);
    check("c6_valid", 32'(bus.instr_valid), 32'd0);
    check("c6_xfer", 32'(xfer_cnt - snap), 32'd1);
    for (int c = 7; c <= 11; c++) step();
    check_hold("second", 32'h0020_0593, 32'h4);
    step();
    check("c12_addr", 32'(bus.rom_addr), 32'h8);

    // Backpressure: ready low for cycles 5..8, transfer at cycle 9.
    bus.instr_ready = 1'b0;
    do_reset();
    snap = xfer_cnt;
    for (int c = 0; c <= 9; c++) begin
      if (c >= 5) begin
        check_hold($sformatf("bp_c%0d", c), 32'h0010_0513, 32'h0);
        check($sformatf("bp_addr_c%0d", c), 32'(bus.rom_addr), 32'h0);
      end
      if (c == 9) bus.instr_ready = 1'b1;
      step();
    end
    check("bp_addr_c10", 32'(bus.rom_addr), 32'h4);
    check("bp_valid_c10", 32'(bus.instr_valid), 32'd0);
    check("bp_xfer", 32'(xfer_cnt - snap), 32'd1);

    // Redirect to 0x40 during cycle 2 of the first fetch.
    do_reset();
    watch_pc0 = 1'b1;
    snap = pc0_valid_cnt;
    step();
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    check("rd_addr_c3", 32'(bus.rom_addr), 32'h40);
    check("rd_misalign_c3", 32'(bus.misalign_err), 32'd0);
    for (int c = 3; c < 8; c++) begin
      check($sformatf("rd_novalid_c%0d", c), 32'(bus.instr_valid), 32'd0);
      step();
    end
    check_hold("rd40", 32'h5634_12B7, 32'h40);
    watch_pc0 = 1'b0;
    check("rd_no_pc0", 32'(pc0_valid_cnt - snap), 32'd0);

    // Misaligned redirect to 0x42 coincident with a handshake (cycle 8).
    snap = xfer_cnt;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h42;
    step();
    bus.redirect_valid = 1'b0;
    check("mis_pulse", 32'(bus.misalign_err), 32'd1);
    check("mis_addr", 32'(bus.rom_addr), 32'h40);
    check("mis_valid", 32'(bus.instr_valid), 32'd0);
    check("hs_redir_xfer", 32'(xfer_cnt - snap), 32'd1);
    step();
    check("mis_pulse_end", 32'(bus.misalign_err), 32'd0);
    for (int c = 10; c < 14; c++) step();
    check_hold("mis40", 32'h5634_12B7, 32'h40);

    // Redirect to 0xFFC with handshake, then wrap of the ROM address.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFC;
    step();
    bus.redirect_valid = 1'b0;
    check("wrap_misalign", 32'(bus.misalign_err), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("wrap_addr_a%0d", c), 32'(bus.rom_addr), 32'hFFC + 32'(c));
      step();
    end
    step();
    check_hold("wrap_ffc", 32'h0000_006F, 32'hFFC);
    step();
    for (int c = 0; c < 4; c++) begin
      check($sformatf("wrap_addr_b%0d", c), 32'(bus.rom_addr), 32'(c));
      step();
    end
    step();
    check_hold("wrap_1000", 32'h0010_0513, 32'h1000);

    // Back-to-back redirects: 0x81 (misaligned) then 0x44.
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h81;
    step();
    bus.redirect_pc = 32'h44;
    check("b2b_pulse1", 32'(bus.misalign_err), 32'd1);
    check("b2b_addr1", 32'(bus.rom_addr), 32'h80);
    step();
    bus.redirect_valid = 1'b0;
    check("b2b_pulse2", 32'(bus.misalign_err), 32'd0);
    check("b2b_addr2", 32'(bus.rom_addr), 32'h44);
    for (int c = 28; c < 33; c++) step();
    check_hold("b2b44", 32'h0031_0233, 32'h44);

    // One-edge reset while holding an instruction.
    rst_n = 1'b0;
    step();
    check("hrst_valid", 32'(bus.instr_valid), 32'd0);
    check("hrst_addr", 32'(bus.rom_addr), 32'h0);
    check("hrst_pc", bus.instr_pc, 32'h0);
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    check("hrst_novalid_c4", 32'(bus.instr_valid), 32'd0);
    step();
    check_hold("hrst_first", 32'h0010_0513, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
